// File: rtl/burst_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// burst_cmd_arbiter
//
// Round-robin arbiter that collects full-burst and tail-burst requests from NUM
// fifo status controllers and turns the winner into one AXI-style command.
// Each grant runs IDLE -> ISSUE -> WAIT_DONE -> RELEASE. The winner sees a resp
// pulse when the master accepts the command and a done pulse when the transfer
// completes. RELEASE always takes one cycle, so done reaches the requester
// before that requester can be granted again.
//
// Optional feature macro: BURST_ARB_TIMEOUT_EN
//   When defined, a completion watchdog is added, with parameter TIMEOUT and
//   output timeout_err. If TIMEOUT cycles pass in WAIT_DONE without cmd_done,
//   the block pulses timeout_err and done[winner] and then releases the grant.
//
// Ports
//   clock      : rising-edge clock
//   rst        : asynchronous, active-high reset
//   burst_req  : per-requester full-burst request level   [NUM]
//   tail_req   : per-requester tail-burst request level   [NUM]
//   req_len    : packed lengths, requester i at [i*LSIZE +: LSIZE]
//   resp       : one-cycle accept pulse to the winner     [NUM]
//   done       : one-cycle completion pulse to the winner [NUM]
//   cmd_valid  : command valid to the master
//   cmd_ready  : master accepts the command
//   cmd_len    : burst length of the command              [LSIZE]
//   cmd_tail   : the command is a tail burst
//   cmd_id     : index of the granted requester           [IDW]
//   cmd_done   : completion pulse from the master
//   busy       : high in every state except IDLE
//   timeout_err: watchdog expiry pulse (only when the macro is defined)
// -----------------------------------------------------------------------------
module burst_cmd_arbiter #(
  parameter int NUM   = 4,
  parameter int LSIZE = 9,
  parameter int IDW   = 3
`ifdef BURST_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 1023
`endif
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [NUM-1:0]       burst_req,
  input  logic [NUM-1:0]       tail_req,
  input  logic [NUM*LSIZE-1:0] req_len,
  output logic [NUM-1:0]       resp,
  output logic [NUM-1:0]       done,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [LSIZE-1:0]     cmd_len,
  output logic                 cmd_tail,
  output logic [IDW-1:0]       cmd_id,
  input  logic                 cmd_done,
`ifdef BURST_ARB_TIMEOUT_EN
  output logic                 timeout_err,
`endif
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  state_t state_r;
  state_t state_s;

  logic [IDW-1:0]   rr_ptr_r;
  logic [NUM-1:0]   req_any_s;
  logic             found_s;
  logic [IDW-1:0]   win_s;
  logic [LSIZE-1:0] win_len_s;
  logic             win_tail_s;
  logic [IDW-1:0]   rr_next_s;
  logic             grant_s;
  logic             accept_s;
  logic             done_ev_s;
  logic             tmo_fire_s;
  logic             tmo_hold_s;
  int               dist_s;
  int               best_s;

  logic             cmd_valid_r;
  logic             cmd_valid_s;
  logic [LSIZE-1:0] cmd_len_r;
  logic             cmd_tail_r;
  logic [IDW-1:0]   cmd_id_r;
  logic [NUM-1:0]   resp_r;
  logic [NUM-1:0]   resp_s;
  logic [NUM-1:0]   done_r;
  logic [NUM-1:0]   done_s;
  logic             busy_r;
  logic             busy_s;

  // A requester asking for a burst, a tail, or both is a candidate.
  assign req_any_s = burst_req | tail_req;
  assign grant_s   = (state_r == IDLE) && found_s;
  assign accept_s  = (state_r == ISSUE) && cmd_ready;

  // Round-robin pick: the candidate nearest to rr_ptr, counting upward and
  // wrapping modulo NUM, wins.
  always_comb begin
    found_s = 1'b0;
    win_s   = {IDW{1'b0}};
    best_s  = NUM;
    dist_s  = 0;
    for (int i = 0; i < NUM; i++) begin
      if (i >= int'(rr_ptr_r)) begin
        dist_s = i - int'(rr_ptr_r);
      end else begin
        dist_s = i - int'(rr_ptr_r) + NUM;
      end
      if (req_any_s[i] && (dist_s < best_s)) begin
        best_s  = dist_s;
        win_s   = IDW'(i);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Fetch the winner's length and tail flag. A tail request takes precedence
  // over a full burst from the same requester.
  always_comb begin
    win_len_s  = {LSIZE{1'b0}};
    win_tail_s = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if (win_s == IDW'(i)) begin
        win_len_s  = req_len[i*LSIZE +: LSIZE];
        win_tail_s = tail_req[i];
      end else begin
        win_tail_s = win_tail_s;
      end
    end
  end

  // The pointer moves one past the winner and wraps after NUM-1.
  assign rr_next_s = (win_s == IDW'(NUM - 1)) ? {IDW{1'b0}} : (win_s + IDW'(1));

`ifdef BURST_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt_r;
  logic          timeout_err_r;

  // The watchdog counts WAIT_DONE cycles. It reads 0 in the first cycle of
  // WAIT_DONE and is cleared in every other state.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wd_cnt_r <= {CW{1'b0}};
    end else if (state_r == WAIT_DONE) begin
      wd_cnt_r <= wd_cnt_r + CW'(1);
    end else begin
      wd_cnt_r <= {CW{1'b0}};
    end
  end

  // The fire cycle is the last counted cycle before the limit; the pulse is
  // registered on its closing edge. The following cycle (count == TIMEOUT)
  // moves to RELEASE and ignores any late cmd_done.
  assign tmo_fire_s = (state_r == WAIT_DONE) && !cmd_done && (wd_cnt_r == CW'(TIMEOUT - 1));
  assign tmo_hold_s = (state_r == WAIT_DONE) && (wd_cnt_r == CW'(TIMEOUT));

  // Registered watchdog expiry pulse.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      timeout_err_r <= 1'b0;
    end else begin
      timeout_err_r <= tmo_fire_s;
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign tmo_fire_s = 1'b0;
  assign tmo_hold_s = 1'b0;
`endif

  assign done_ev_s = (state_r == WAIT_DONE) && ((cmd_done && !tmo_hold_s) || tmo_fire_s);

  // FSM state register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          state_s = WAIT_DONE;
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT_DONE: begin
        if (tmo_hold_s || cmd_done) begin
          state_s = RELEASE;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      RELEASE: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs. The pulses go
  // to the granted requester only, so at most one bit is ever set.
  always_comb begin
    cmd_valid_s = (state_s == ISSUE);
    busy_s      = (state_s != IDLE);
    resp_s      = {NUM{1'b0}};
    done_s      = {NUM{1'b0}};
    for (int i = 0; i < NUM; i++) begin
      resp_s[i] = accept_s && (cmd_id_r == IDW'(i));
      done_s[i] = done_ev_s && (cmd_id_r == IDW'(i));
    end
  end

  // Output and command registers. The command fields are captured only on
  // the grant edge, so later request changes cannot disturb them.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cmd_valid_r <= 1'b0;
      cmd_len_r   <= {LSIZE{1'b0}};
      cmd_tail_r  <= 1'b0;
      cmd_id_r    <= {IDW{1'b0}};
      rr_ptr_r    <= {IDW{1'b0}};
      resp_r      <= {NUM{1'b0}};
      done_r      <= {NUM{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      cmd_valid_r <= cmd_valid_s;
      resp_r      <= resp_s;
      done_r      <= done_s;
      busy_r      <= busy_s;
      if (grant_s) begin
        cmd_len_r  <= win_len_s;
        cmd_tail_r <= win_tail_s;
        cmd_id_r   <= win_s;
        rr_ptr_r   <= rr_next_s;
      end else begin
        cmd_id_r   <= cmd_id_r;
      end
    end
  end

  assign cmd_valid = cmd_valid_r;
  assign cmd_len   = cmd_len_r;
  assign cmd_tail  = cmd_tail_r;
  assign cmd_id    = cmd_id_r;
  assign resp      = resp_r;
  assign done      = done_r;
  assign busy      = busy_r;

endmodule

// File: doc/burst_cmd_arbiter.md
BURST_CMD_ARBITER -- requirements
Module: burst_cmd_arbiter

Interface
REQ-001 SHALL have parameter NUM, default 4: number of requesters (fifo status controllers), range 2..8.
REQ-002 SHALL have parameter LSIZE, default 9: burst length width.
REQ-003 SHALL have parameter IDW, default 3: command ID width, with 2**IDW >= NUM.
REQ-004 SHALL have port clock  in  1: single clock; all logic on the rising edge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-006 SHALL have port burst_req  in  NUM: per-requester full-burst request level.
REQ-007 SHALL have port tail_req  in  NUM: per-requester tail-burst request level.
REQ-008 SHALL have port req_len  in  NUM*LSIZE: packed lengths; requester i occupies bits [i*LSIZE +: LSIZE].
REQ-009 SHALL have port resp  out  NUM: one-cycle pulse to the winner when its command is accepted.
REQ-010 SHALL have port done  out  NUM: one-cycle pulse to the winner when its transfer completes.
REQ-011 SHALL have port cmd_valid  out  1: command valid to the AXI master.
REQ-012 SHALL have port cmd_ready  in  1: AXI master accepts the command.
REQ-013 SHALL have port cmd_len  out  LSIZE: burst length of the command.
REQ-014 SHALL have port cmd_tail  out  1: command is a tail burst.
REQ-015 SHALL have port cmd_id  out  IDW: index of the granted requester.
REQ-016 SHALL have port cmd_done  in  1: pulse from the master when the granted transfer completes.
REQ-017 SHALL have port busy  out  1: high in every state except IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT_DONE, RELEASE.
REQ-019 IDLE SHALL move to ISSUE when any bit of (burst_req | tail_req) is set, otherwise stay in IDLE.
- On that edge the block registers the winner index, req_len of the winner, and tail flag.
REQ-020 Arbitration SHALL be round-robin.
- Search starts at index rr_ptr and wraps modulo NUM.
- rr_ptr is loaded with winner+1 (wrapping to 0 after NUM-1) on grant.
REQ-021 If a requester has both burst_req and tail_req set, the block SHALL grant it as a tail with cmd_tail=1.
REQ-022 In ISSUE, cmd_valid SHALL be 1, and cmd_len, cmd_tail and cmd_id SHALL hold the registered values stable until cmd_ready.
REQ-023 When cmd_valid && cmd_ready, the block SHALL pulse resp[winner] on the next cycle and move to WAIT_DONE.
- cmd_valid drops in the cycle after acceptance.
REQ-024 In WAIT_DONE, cmd_done SHALL pulse done[winner] on the next cycle and move to RELEASE.
- cmd_done in any other state is ignored.
REQ-025 RELEASE SHALL last exactly one cycle, then return to IDLE, so a requester sees done before it can be re-granted.
REQ-026 Request changes outside IDLE SHALL NOT alter the registered command.
- A request withdrawn during ISSUE is still issued.
REQ-027 At most one bit of resp and one bit of done SHALL be high in any cycle.
REQ-028 Minimum grant-to-grant spacing SHALL be 4 cycles (IDLE, ISSUE, WAIT_DONE, RELEASE), with cmd_ready and cmd_done each immediate.

Reset
REQ-029 While rst=1 the block SHALL hold these values, asynchronously:
- state IDLE, rr_ptr 0
- cmd_valid, cmd_len, cmd_tail, cmd_id = 0
- resp, done = 0
- busy = 0
- timeout_err = 0 (when present)
REQ-030 Reset asserted mid-transfer SHALL abandon the command with no resp or done pulse.
- The first grant after reset starts the search at index 0.

Configuration
REQ-031 Macro BURST_ARB_TIMEOUT_EN SHALL control the completion watchdog.
- When defined: add parameter TIMEOUT (default 1023) and output timeout_err (out, 1).
- A counter of WAIT_DONE cycles starts at 0 on entry to WAIT_DONE.
- When the count reaches TIMEOUT without cmd_done, the block pulses timeout_err and done[winner] for one cycle, then enters RELEASE.
- When undefined: no counter and no timeout_err port; WAIT_DONE waits indefinitely.

Verification
REQ-032 Reset, then burst_req=4'b0001 with len 100, cmd_ready held high, cmd_done 3 cycles after acceptance -> cmd_len=100, cmd_tail=0, cmd_id=0, then one resp[0] pulse and one done[0] pulse.
REQ-033 burst_req=4'b1111 held, immediate ready/done -> grants in order 0,1,2,3,0, each 4 cycles apart.
REQ-034 tail_req[2]=1 and burst_req[2]=1 with len 37 -> cmd_tail=1, cmd_len=37, cmd_id=2.
REQ-035 cmd_ready held low 10 cycles with req_len changing -> cmd_valid stays high with cmd_len unchanged; resp fires 1 cycle after ready.
REQ-036 rst pulsed during WAIT_DONE -> no done pulse; outputs zero; the next grant to requester 3 (with requester 1 also pending) goes to 1.
REQ-037 With BURST_ARB_TIMEOUT_EN defined, TIMEOUT=15, and cmd_done never asserted -> timeout_err and done[winner] pulse 15 cycles after entering WAIT_DONE, and busy drops 2 cycles later.
